dp_ram_clr: RTL and testbench
=============================

DP_RAM_CLR -- requirements
Module: dp_ram_clr

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 4, address width; depth = 2**ADDR_SIZE words.
REQ-002 SHALL have parameter DATA_SIZE, default 8, word width; must be a multiple of 8.
REQ-003 SHALL have parameter RD_MODE, default 0, same-address collision policy: 0 = read-first (old data), 1 = write-first (new data).
REQ-004 SHALL have parameter OUT_REG, default 0, adds one output pipeline stage when 1.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-007 SHALL have port clear, input, 1, single-cycle pulse requesting memory zero-fill.
REQ-008 SHALL have port busy, output, 1, high while zero-fill is in progress.
REQ-009 SHALL have port A ports: en_A (in, 1), w_e_A (in, 1), be_A (in, DATA_SIZE/8), addr_A (in, ADDR_SIZE), data_in_A (in, DATA_SIZE), data_out_A (out, DATA_SIZE), valid_A (out, 1).
REQ-010 SHALL have port B ports (read-only): en_B (in, 1), addr_B (in, ADDR_SIZE), data_out_B (out, DATA_SIZE), valid_B (out, 1).

Function
REQ-011 Port A write: en_A=1, w_e_A=1, busy=0 -> byte lane i of word addr_A updated only where be_A[i]=1.
REQ-012 Port A read: en_A=1, w_e_A=0, busy=0 -> data_out_A/valid_A present word after 1+OUT_REG cycles; valid_A is a one-cycle pulse per accepted read.
REQ-013 Port A write SHALL also return a read (read-first or write-first per RD_MODE) with valid_A pulsed, same latency.
REQ-014 Port B read: en_B=1, busy=0 -> data_out_B/valid_B after 1+OUT_REG cycles, one pulse per accepted read.
REQ-015 Collision (A writes addr X, B reads X same cycle): RD_MODE=0 -> B returns pre-write word; RD_MODE=1 -> B returns merged post-write word (byte-enable applied).
REQ-016 data_out_A/data_out_B SHALL hold last value when valid low.
REQ-017 Clear FSM states: IDLE, CLEAR. IDLE->CLEAR on clear=1; CLEAR writes zero to counter address, one word per cycle, counter 0..2**ADDR_SIZE-1; CLEAR->IDLE after last address written.
REQ-018 busy SHALL equal (state==CLEAR); zero-fill takes exactly 2**ADDR_SIZE cycles.
REQ-019 clear asserted during CLEAR SHALL restart the counter at 0.
REQ-020 While busy=1, port A and B accesses SHALL be ignored: no write, no valid pulse; reads in flight in the pipeline when CLEAR starts still complete.
REQ-021 Counter SHALL not wrap beyond depth; address width exactly ADDR_SIZE bits, terminal count detected at all-ones.

Reset
REQ-022 reset SHALL asynchronously force state=CLEAR, counter=0, valid_A=0, valid_B=0, data_out_A=0, data_out_B=0, pipeline registers cleared.
REQ-023 Memory contents SHALL be zero after reset deassertion + 2**ADDR_SIZE cycles; busy=1 immediately out of reset.
REQ-024 reset mid-CLEAR or mid-read SHALL abort and restart zero-fill from address 0; no valid pulse survives reset.

Structure
REQ-025 Shared package dp_ram_pkg SHALL hold the FSM state enum (IDLE, CLEAR) and RD_MODE constants (RD_FIRST=0, WR_FIRST=1).
REQ-026 One sub-module dp_ram_outreg (data+valid pipeline stage, generated when OUT_REG=1) SHALL be instantiated per port; memory array stays in top.

Verification
REQ-027 Reset release, depth 16 -> busy high exactly 16 cycles, then reads of all addresses return 0x00.
REQ-028 Write A addr 3 data 0xA5 be 1; read A addr 3 -> 0xA5, valid_A one cycle after issue (OUT_REG=0), two cycles (OUT_REG=1).
REQ-029 DATA_SIZE=16: write 0x1234 at addr 5, then write 0xFF00 be=2'b10 -> read returns 0xFF34.
REQ-030 Collision at addr 7 (old 0x11, write 0x22): RD_MODE=0 -> data_out_B=0x11; RD_MODE=1 -> 0x22.
REQ-031 clear pulse at cycle 5 of a CLEAR -> busy stays high 16 further cycles; A write during busy leaves word 0x00, no valid.
REQ-032 reset asserted mid-read with OUT_REG=1 -> valid_A/valid_B stay 0, data_out 0, busy=1 next cycle.

Source files
------------

// File: rtl/dp_ram_pkg.sv
// Shared types and constants for the dual-port RAM with zero-fill clear.
package dp_ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int unsigned RD_FIRST = 0;
    localparam int unsigned WR_FIRST = 1;

endpackage

// File: rtl/dp_ram_outreg.sv
// Optional output pipeline stage: registers data and valid, holds data while valid is low.
module dp_ram_outreg #(
    parameter int unsigned DATA_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] i_data,
    input  logic                 i_valid,
    output logic [DATA_SIZE-1:0] o_data,
    output logic                 o_valid
);

    logic [DATA_SIZE-1:0] r_data;
    logic                 r_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/dp_ram_clr.sv
// Dual-port RAM (port A read/write with byte enables, port B read-only) with a
// zero-fill clear engine that also runs automatically out of reset.
module dp_ram_clr
    import dp_ram_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 4,
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned RD_MODE   = RD_FIRST,
    parameter int unsigned OUT_REG   = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    output logic                   busy,
    input  logic                   en_A,
    input  logic                   w_e_A,
    input  logic [DATA_SIZE/8-1:0] be_A,
    input  logic [ADDR_SIZE-1:0]   addr_A,
    input  logic [DATA_SIZE-1:0]   data_in_A,
    output logic [DATA_SIZE-1:0]   data_out_A,
    output logic                   valid_A,
    input  logic                   en_B,
    input  logic [ADDR_SIZE-1:0]   addr_B,
    output logic [DATA_SIZE-1:0]   data_out_B,
    output logic                   valid_B
);

    localparam int unsigned DEPTH = 2**ADDR_SIZE;
    localparam int unsigned NB    = DATA_SIZE / 8;

    logic [DATA_SIZE-1:0] r_mem [DEPTH];

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADDR_SIZE-1:0] r_cnt;
    logic [ADDR_SIZE-1:0] w_cnt_nxt;

    logic                 w_acc_A;
    logic                 w_wr_A;
    logic                 w_acc_B;
    logic                 w_coll;
    logic [DATA_SIZE-1:0] w_old_A;
    logic [DATA_SIZE-1:0] w_old_B;
    logic [DATA_SIZE-1:0] w_merged;
    logic [DATA_SIZE-1:0] w_rd_A;
    logic [DATA_SIZE-1:0] w_rd_B;

    logic                 r_vld_A;
    logic                 r_vld_B;
    logic [DATA_SIZE-1:0] r_dat_A;
    logic [DATA_SIZE-1:0] r_dat_B;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A clear request while already clearing restarts the sweep from address 0.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (clear) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                if (clear) begin
                    w_cnt_nxt = '0;
                end else if (&r_cnt) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + ADDR_SIZE'(1);
                end
            end
            default: begin
                w_state_nxt = CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign busy = (r_state == CLEAR);

    assign w_acc_A = en_A & ~busy;
    assign w_wr_A  = w_acc_A & w_e_A;
    assign w_acc_B = en_B & ~busy;
    assign w_coll  = w_wr_A && (addr_A == addr_B);
    assign w_old_A = r_mem[addr_A];
    assign w_old_B = r_mem[addr_B];

    always_comb begin
        w_merged = w_old_A;
        for (int unsigned i = 0; i < NB; i++) begin
            if (be_A[i]) begin
                w_merged[8*i +: 8] = data_in_A[8*i +: 8];
            end
        end
    end

    assign w_rd_A = (RD_MODE == WR_FIRST && w_wr_A) ? w_merged : w_old_A;
    assign w_rd_B = (RD_MODE == WR_FIRST && w_coll) ? w_merged : w_old_B;

    // Clear sweep owns the write port while busy; user accesses are dropped.
    always_ff @(posedge clk) begin
        if (busy) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_A) begin
            r_mem[addr_A] <= w_merged;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_A <= 1'b0;
            r_vld_B <= 1'b0;
            r_dat_A <= '0;
            r_dat_B <= '0;
        end else begin
            r_vld_A <= w_acc_A;
            r_vld_B <= w_acc_B;
            if (w_acc_A) begin
                r_dat_A <= w_rd_A;
            end
            if (w_acc_B) begin
                r_dat_B <= w_rd_B;
            end
        end
    end

    generate
        if (OUT_REG == 1) begin : g_outreg
            dp_ram_outreg #(.DATA_SIZE(DATA_SIZE)) u_out_A (
                .clk     (clk),
                .reset   (reset),
                .i_data  (r_dat_A),
                .i_valid (r_vld_A),
                .o_data  (data_out_A),
                .o_valid (valid_A)
            );
            dp_ram_outreg #(.DATA_SIZE(DATA_SIZE)) u_out_B (
                .clk     (clk),
                .reset   (reset),
                .i_data  (r_dat_B),
                .i_valid (r_vld_B),
                .o_data  (data_out_B),
                .o_valid (valid_B)
            );
        end else begin : g_direct
            assign data_out_A = r_dat_A;
            assign valid_A    = r_vld_A;
            assign data_out_B = r_dat_B;
            assign valid_B    = r_vld_B;
        end
    endgenerate

endmodule

// File: tb/tb_dp_ram_clr.sv
// Directed bench: u0 = 8-bit read-first no out-reg, u1 = 16-bit write-first with out-reg.
module tb_dp_ram_clr;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        en_a, we_a, en_b;
    logic [1:0]  be_a;
    logic [3:0]  addr_a, addr_b;
    logic [15:0] din_a;

    logic        busy0, vA0, vB0;
    logic [7:0]  dA0, dB0;
    logic        busy1, vA1, vB1;
    logic [15:0] dA1, dB1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dp_ram_clr #(.ADDR_SIZE(4), .DATA_SIZE(8), .RD_MODE(0), .OUT_REG(0)) u0 (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy0),
        .en_A(en_a), .w_e_A(we_a), .be_A(be_a[0:0]), .addr_A(addr_a),
        .data_in_A(din_a[7:0]), .data_out_A(dA0), .valid_A(vA0),
        .en_B(en_b), .addr_B(addr_b), .data_out_B(dB0), .valid_B(vB0)
    );

    dp_ram_clr #(.ADDR_SIZE(4), .DATA_SIZE(16), .RD_MODE(1), .OUT_REG(1)) u1 (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy1),
        .en_A(en_a), .w_e_A(we_a), .be_A(be_a), .addr_A(addr_a),
        .data_in_A(din_a), .data_out_A(dA1), .valid_A(vA1),
        .en_B(en_b), .addr_B(addr_b), .data_out_B(dB1), .valid_B(vB1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, ".busy0"}, {15'd0, busy0}, 16'd1);
        chk({tag, ".busy1"}, {15'd0, busy1}, 16'd1);
        chk({tag, ".vA0"}, {15'd0, vA0}, 16'd0);
        chk({tag, ".vB0"}, {15'd0, vB0}, 16'd0);
        chk({tag, ".vA1"}, {15'd0, vA1}, 16'd0);
        chk({tag, ".vB1"}, {15'd0, vB1}, 16'd0);
        chk({tag, ".dA0"}, {8'd0, dA0}, 16'd0);
        chk({tag, ".dB0"}, {8'd0, dB0}, 16'd0);
        chk({tag, ".dA1"}, dA1, 16'd0);
        chk({tag, ".dB1"}, dB1, 16'd0);
    endtask

    // Issue one access cycle, then check u0 after one edge and u1 after two.
    task automatic access(input string tag, input logic ea, input logic we, input logic [1:0] be,
                          input logic [3:0] aa, input logic [15:0] din, input logic eb,
                          input logic [3:0] ab, input logic [15:0] e0a, input logic [15:0] e0b,
                          input logic [15:0] e1a, input logic [15:0] e1b);
        en_a = ea; we_a = we; be_a = be; addr_a = aa; din_a = din; en_b = eb; addr_b = ab;
        tick();
        en_a = 1'b0; we_a = 1'b0; be_a = 2'b00; en_b = 1'b0;
        chk({tag, ".c1.vA0"}, {15'd0, vA0}, {15'd0, ea});
        chk({tag, ".c1.vB0"}, {15'd0, vB0}, {15'd0, eb});
        if (ea) chk({tag, ".c1.dA0"}, {8'd0, dA0}, e0a);
        if (eb) chk({tag, ".c1.dB0"}, {8'd0, dB0}, e0b);
        chk({tag, ".c1.vA1"}, {15'd0, vA1}, 16'd0);
        chk({tag, ".c1.vB1"}, {15'd0, vB1}, 16'd0);
        tick();
        chk({tag, ".c2.vA0"}, {15'd0, vA0}, 16'd0);
        chk({tag, ".c2.vB0"}, {15'd0, vB0}, 16'd0);
        if (ea) chk({tag, ".c2.holdA0"}, {8'd0, dA0}, e0a);
        chk({tag, ".c2.vA1"}, {15'd0, vA1}, {15'd0, ea});
        chk({tag, ".c2.vB1"}, {15'd0, vB1}, {15'd0, eb});
        if (ea) chk({tag, ".c2.dA1"}, dA1, e1a);
        if (eb) chk({tag, ".c2.dB1"}, dB1, e1b);
    endtask

    task automatic count_busy(input string tag);
        int n0 = 0;
        int n1 = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy0) n0++;
            if (busy1) n1++;
            tick();
        end
        chk({tag, ".n0"}, 16'(n0), 16'd16);
        chk({tag, ".n1"}, 16'(n1), 16'd16);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0;
        en_a = 1'b0; we_a = 1'b0; be_a = 2'b00; addr_a = 4'd0; din_a = 16'd0;
        en_b = 1'b0; addr_b = 4'd0;
        tick();
        tick();
        chk_rst("rst");

        // Zero-fill out of reset, then every word reads back as zero.
        reset = 1'b0;
        count_busy("boot");
        for (int a = 0; a < 16; a++) begin
            access("zero", 1'b1, 1'b0, 2'b00, 4'(a), 16'd0, 1'b1, 4'(15 - a),
                   16'h0, 16'h0, 16'h0, 16'h0);
        end

        access("wr3", 1'b1, 1'b1, 2'b01, 4'd3, 16'h00A5, 1'b0, 4'd0,
               16'h0000, 16'h0, 16'h00A5, 16'h0);
        access("rd3", 1'b1, 1'b0, 2'b00, 4'd3, 16'h0, 1'b1, 4'd3,
               16'h00A5, 16'h00A5, 16'h00A5, 16'h00A5);

        access("wr5a", 1'b1, 1'b1, 2'b11, 4'd5, 16'h1234, 1'b0, 4'd0,
               16'h0000, 16'h0, 16'h1234, 16'h0);
        access("wr5b", 1'b1, 1'b1, 2'b10, 4'd5, 16'hFF00, 1'b0, 4'd0,
               16'h0034, 16'h0, 16'hFF34, 16'h0);
        access("rd5", 1'b1, 1'b0, 2'b00, 4'd5, 16'h0, 1'b1, 4'd5,
               16'h0034, 16'h0034, 16'hFF34, 16'hFF34);

        access("wr7", 1'b1, 1'b1, 2'b11, 4'd7, 16'h0011, 1'b0, 4'd0,
               16'h0000, 16'h0, 16'h0011, 16'h0);
        access("coll7", 1'b1, 1'b1, 2'b11, 4'd7, 16'h0022, 1'b1, 4'd7,
               16'h0011, 16'h0011, 16'h0022, 16'h0022);
        access("rd7", 1'b1, 1'b0, 2'b00, 4'd7, 16'h0, 1'b1, 4'd7,
               16'h0022, 16'h0022, 16'h0022, 16'h0022);

        // Clear, restart it partway through, and try a write while busy.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("clr.busy0", {15'd0, busy0}, 16'd1);
            tick();
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        begin
            int n0 = 0;
            int n1 = 0;
            for (int i = 0; i < 20; i++) begin
                if (i == 0) begin
                    en_a = 1'b1; we_a = 1'b1; be_a = 2'b11; addr_a = 4'd3; din_a = 16'h00FF;
                end else if (i == 1) begin
                    en_a = 1'b0; we_a = 1'b0; be_a = 2'b00;
                end
                if (busy0) n0++;
                if (busy1) n1++;
                if (i < 3) begin
                    chk("busywr.vA0", {15'd0, vA0}, 16'd0);
                    chk("busywr.vA1", {15'd0, vA1}, 16'd0);
                end
                tick();
            end
            chk("restart.n0", 16'(n0), 16'd16);
            chk("restart.n1", 16'(n1), 16'd16);
        end
        access("clr3", 1'b1, 1'b0, 2'b00, 4'd3, 16'h0, 1'b1, 4'd7,
               16'h0, 16'h0, 16'h0, 16'h0);

        // Reset while a read is in the out-reg pipeline.
        access("wr1", 1'b1, 1'b1, 2'b11, 4'd1, 16'hBEEF, 1'b0, 4'd0,
               16'h0000, 16'h0, 16'hBEEF, 16'h0);
        en_a = 1'b1; addr_a = 4'd1; en_b = 1'b1; addr_b = 4'd1;
        tick();
        en_a = 1'b0; en_b = 1'b0;
        chk("midrd.vA0", {15'd0, vA0}, 16'd1);
        chk("midrd.dA0", {8'd0, dA0}, 16'h00EF);
        reset = 1'b1;
        #1;
        chk_rst("rst_mid");
        tick();
        chk_rst("rst_mid2");
        reset = 1'b0;
        count_busy("reboot");
        access("rd1", 1'b1, 1'b0, 2'b00, 4'd1, 16'h0, 1'b1, 4'd1,
               16'h0, 16'h0, 16'h0, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
